// File: rtl/load_pkg.sv
// Shared types and decode helpers for the load unit.
package load_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RSP,
        S_DONE
    } state_e;

    function automatic logic is_legal(input logic [2:0] f);
        case (f)
            LB, LH, LW, LBU, LHU: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f, input logic [1:0] off);
        case (f)
            LH, LHU: return off[0];
            LW:      return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // True when the access spills into the following word.
    function automatic logic crosses_word(input logic [2:0] f, input logic [1:0] off);
        case (f)
            LH, LHU: return off == 2'b11;
            LW:      return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Byte-lane shift, width select and sign/zero extension of a load result.
module load_align
    import load_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] beat0,
    input  logic [31:0] beat1,
    output logic [31:0] data
);

    logic [31:0] window;

    always_comb begin
        window = 32'({beat1, beat0} >> {offset, 3'b000});
        case (funct3)
            LB:      data = {{24{window[7]}}, window[7:0]};
            LH:      data = {{16{window[15]}}, window[15:0]};
            LW:      data = window;
            LBU:     data = {24'd0, window[7:0]};
            LHU:     data = {16'd0, window[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: one outstanding word-read load with alignment and extension.
// Define LOAD_MISALIGN_SPLIT_EN to service misaligned loads (two reads when crossing a word).
//
// state  | meaning
// IDLE   | ready for a new load request
// REQ    | word read presented to memory, waiting for mem_req_ready
// RSP    | waiting for the read data of the current beat
// DONE   | result (or fault) presented for one cycle
module load_unit
    import load_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        load_fault
);

    state_e      state, state_nx;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic        accept, req_bad, last_beat, finish_ok;
    logic [31:0] align_beat0, align_beat1, align_data;

`ifdef LOAD_MISALIGN_SPLIT_EN
    logic        beat_q;
    logic [31:0] beat0_q;

    assign last_beat    = !crosses_word(funct3_q, addr_q[1:0]) || beat_q;
    assign align_beat0  = beat_q ? beat0_q : mem_rsp_data;
    assign align_beat1  = mem_rsp_data;
    assign mem_req_addr = {addr_q[31:2], 2'b00} + {29'd0, beat_q, 2'b00};
    assign req_bad      = !is_legal(req_funct3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q  <= 1'b0;
            beat0_q <= '0;
        end else if (accept) begin
            beat_q <= 1'b0;
        end else if (state == S_RSP && mem_rsp_valid && !last_beat) begin
            beat_q  <= 1'b1;
            beat0_q <= mem_rsp_data;
        end
    end
`else
    assign last_beat    = 1'b1;
    assign align_beat0  = mem_rsp_data;
    assign align_beat1  = '0;
    assign mem_req_addr = {addr_q[31:2], 2'b00};
    assign req_bad      = !is_legal(req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
`endif

    load_align u_align (
        .funct3 (funct3_q),
        .offset (addr_q[1:0]),
        .beat0  (align_beat0),
        .beat1  (align_beat1),
        .data   (align_data)
    );

    always_comb begin
        state_nx      = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        load_valid    = 1'b0;
        accept        = 1'b0;
        finish_ok     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    state_nx = req_bad ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nx = S_RSP;
            end
            S_RSP: begin
                if (mem_rsp_valid) begin
                    if (last_beat) begin
                        finish_ok = 1'b1;
                        state_nx  = S_DONE;
                    end else begin
                        state_nx = S_REQ;
                    end
                end
            end
            S_DONE: begin
                load_valid = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Result registers are written only on entry to DONE so they hold between loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            funct3_q   <= '0;
            addr_q     <= '0;
            load_data  <= '0;
            load_fault <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                if (req_bad) begin
                    load_data  <= '0;
                    load_fault <= 1'b1;
                end
            end
            if (finish_ok) begin
                load_data  <= align_data;
                load_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with a byte-level reference model and per-cycle checking.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_fault;

`ifdef LOAD_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          lat;
        bit          chk_lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] mem[logic [31:0]];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          hs_count = 0;
    int          rsp_delay = 0;
    logic [31:0] last_hs_addr = '0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_addr = '0;
    exp_t        cur;

    load_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_fault    (load_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h9E37_79B9;
    endfunction

    // Reference: gather the addressed bytes little-endian, then extend.
    function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                  output logic [31:0] d, output logic flt, output int nb);
        int          size;
        logic [31:0] v;
        logic [31:0] ba;
        logic [31:0] w;
        logic        sgn;
        d = '0; flt = 1'b0; nb = 0;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        if (size == 0) begin flt = 1'b1; return; end
        if ((int'(a[1:0]) % size) != 0 && !SPLIT) begin flt = 1'b1; return; end
        v = '0;
        for (int i = 0; i < size; i++) begin
            ba = a + 32'(i);
            w  = mem_word({ba[31:2], 2'b00});
            v[8*i +: 8] = w[{ba[1:0], 3'b000} +: 8];
        end
        if (!f3[2] && size < 4) begin
            sgn = v[8*size-1];
            for (int k = 8*size; k < 32; k++) v[k] = sgn;
        end
        d  = v;
        nb = (int'(a[1:0]) + size > 4) ? 2 : 1;
    endfunction

    // Memory responder: answers each handshake after rsp_delay extra cycles.
    initial begin
        logic [31:0] ha;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mem_req_valid && mem_req_ready) begin
                ha = mem_req_addr;
                hs_count++;
                last_hs_addr = ha;
                if (exp_addr_q.size() == 0) chk("unexpected_mem_req", ha, 32'hxxxx_xxxx);
                else chk("mem_req_addr", ha, exp_addr_q.pop_front());
                @(posedge clk);
                repeat (rsp_delay) @(posedge clk);
                #1;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_word(ha);
                @(posedge clk);
                #1;
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = '0;
            end
        end
    end

    // Per-cycle compare against the model queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("req_ready", 32'(req_ready), 32'(exp_q.size() == 0));
            if (mem_req_valid) chk("mem_req_addr_lsb", 32'(mem_req_addr[1:0]), 32'd0);
            if (prev_valid && !prev_ready) begin
                chk("mem_req_valid_held", 32'(mem_req_valid), 32'd1);
                chk("mem_req_addr_stable", mem_req_addr, prev_addr);
            end
            if (load_valid) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_load_valid", 32'(load_valid), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("load_data", load_data, cur.data);
                    chk("load_fault", 32'(load_fault), 32'(cur.fault));
                    if (cur.chk_lat) chk("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                end
            end
        end
        prev_valid = mem_req_valid;
        prev_ready = mem_req_ready;
        prev_addr  = mem_req_addr;
    end

    task automatic start_load(input logic [2:0] f3, input logic [31:0] addr, input bit chk_lat);
        exp_t e;
        int   nb;
        int   guard;
        model(f3, addr, e.data, e.fault, nb);
        e.lat     = e.fault ? 1 : 2*nb + 1;
        e.chk_lat = chk_lat;
        @(posedge clk); #1;
        req_valid = 1'b1; req_funct3 = f3; req_addr = addr;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!req_ready && guard < 20);
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        e.acc = cyc;
        if (!e.fault) begin
            exp_addr_q.push_back({addr[31:2], 2'b00});
            if (nb == 2) exp_addr_q.push_back({addr[31:2], 2'b00} + 32'd4);
        end
        exp_q.push_back(e);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input int stall);
        int start;
        int guard;
        start = done_cnt;
        if (stall > 0) mem_req_ready = 1'b0;
        start_load(f3, addr, stall == 0);
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1; mem_req_ready = 1'b1;
        end
        guard = 0;
        while (done_cnt == start && guard < 60) begin @(posedge clk); guard++; end
        if (done_cnt == start) chk("load_timeout", 32'(done_cnt - start), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [2:0]  vec_f3[12];
    logic [31:0] vec_addr[12];

    initial begin
        int hs0, dc0;
        rst_n = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_addr = '0; mem_req_ready = 1'b1;
        mem[32'h100] = 32'h80FF_1234;
        mem[32'h200] = 32'hBEEF_0000;
        mem[32'h300] = 32'h4433_2211;
        mem[32'h304] = 32'h8877_6655;
        mem[32'h400] = 32'hCAFE_F00D;
        mem[32'h500] = 32'h7F80_017F;
        mem[32'h504] = 32'h0102_0304;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_load_valid", 32'(load_valid), 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_load_fault", 32'(load_fault), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_load(3'b000, 32'h103, 0);
        chk("lb_103_data", load_data, 32'hFFFF_FF80);
        chk("lb_103_fault", 32'(load_fault), 32'd0);
        chk("lb_103_addr", last_hs_addr, 32'h100);

        do_load(3'b101, 32'h202, 0);
        chk("lhu_202_data", load_data, 32'h0000_BEEF);
        do_load(3'b001, 32'h202, 0);
        chk("lh_202_data", load_data, 32'hFFFF_BEEF);

        hs0 = hs_count;
        do_load(3'b010, 32'h301, 0);
`ifdef LOAD_MISALIGN_SPLIT_EN
        chk("lw_301_data", load_data, 32'h5544_3322);
        chk("lw_301_beats", 32'(hs_count - hs0), 32'd2);
`else
        chk("lw_301_fault", 32'(load_fault), 32'd1);
        chk("lw_301_no_mem", 32'(hs_count - hs0), 32'd0);
`endif

        hs0 = hs_count;
        do_load(3'b011, 32'h100, 0);
        chk("f3_011_fault", 32'(load_fault), 32'd1);
        chk("f3_011_data", load_data, 32'd0);
        chk("f3_011_no_mem", 32'(hs_count - hs0), 32'd0);

        hs0 = hs_count; dc0 = done_cnt;
        do_load(3'b010, 32'h400, 4);
        repeat (3) @(posedge clk);
        chk("stall_data", load_data, 32'hCAFE_F00D);
        chk("stall_handshakes", 32'(hs_count - hs0), 32'd1);
        chk("stall_load_valid", 32'(done_cnt - dc0), 32'd1);

        vec_f3[0]  = 3'b100; vec_addr[0]  = 32'h500;
        vec_f3[1]  = 3'b100; vec_addr[1]  = 32'h503;
        vec_f3[2]  = 3'b000; vec_addr[2]  = 32'h501;
        vec_f3[3]  = 3'b000; vec_addr[3]  = 32'h502;
        vec_f3[4]  = 3'b001; vec_addr[4]  = 32'h502;
        vec_f3[5]  = 3'b001; vec_addr[5]  = 32'h501;
        vec_f3[6]  = 3'b101; vec_addr[6]  = 32'h503;
        vec_f3[7]  = 3'b010; vec_addr[7]  = 32'h502;
        vec_f3[8]  = 3'b010; vec_addr[8]  = 32'h503;
        vec_f3[9]  = 3'b110; vec_addr[9]  = 32'h500;
        vec_f3[10] = 3'b111; vec_addr[10] = 32'h504;
        vec_f3[11] = 3'b010; vec_addr[11] = 32'hFFFF_FFFC;
        for (int i = 0; i < 12; i++) do_load(vec_f3[i], vec_addr[i], 0);

        // Reset while waiting for read data; the late response must be ignored.
        rsp_delay = 4;
        dc0 = done_cnt;
        start_load(3'b000, 32'h100, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_load_valid", 32'(done_cnt - dc0), 32'd0);
        chk("rst_mid_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mid_load_fault", 32'(load_fault), 32'd0);
        chk("rst_mid_load_data", load_data, 32'd0);
        chk("rst_mid_mem_req_addr", mem_req_addr, 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        rsp_delay = 0;

        do_load(3'b100, 32'h103, 0);
        chk("after_rst_lbu", load_data, 32'h0000_0080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
